// File: rtl/xc_aesmix.sv
`timescale 1ns / 1ps
// xc_aesmix: byte-serial AES MixColumns / InvMixColumns unit.
//
// Consumes one column whose bytes are packed the way the SubBytes unit returns them
// (a0 = rs1[7:0], a1 = rs1[15:8], a2 = rs2[23:16], a3 = rs2[31:24]). It produces one
// output byte per cycle over four cycles through a single GF(2^8) multiply-accumulate.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   valid   in   instruction request, held by the core until ready
//   rs1     in   [31:0] source register 1 (a0, a1 in the low half)
//   rs2     in   [31:0] source register 2 (a2, a3 in the high half)
//   enc     in   1 = MixColumns, 0 = InvMixColumns
//   ready   out  one-cycle completion pulse
//   result  out  [31:0] {b3, b2, b1, b0}
//
// Optional feature macro: XC_AESMIX_CLEAR_EN. When it is defined, the captured column
// and the result register are wiped on the cycle after DONE, so the column data does not
// linger while the unit is idle.
module xc_aesmix (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] col_q, col_d;   // {a3, a2, a1, a0}
  logic        enc_q, enc_d;
  logic [31:0] res_q, res_d;
  logic [7:0]  mix_byte;

  // The unused halves of rs1 and rs2 belong to the other columns of the packed state.
  logic unused_rs;
  assign unused_rs = ^{rs1[31:16], rs2[15:0]};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient used here fits in four bits, so the product is the XOR of the
  // x1/x2/x4/x8 xtime chain terms selected by the coefficient bits.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
           (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [3:0] coef(input logic fwd, input logic [1:0] j);
    logic [3:0] c;
    unique case (j)
      2'd0:    c = fwd ? 4'h2 : 4'he;
      2'd1:    c = fwd ? 4'h3 : 4'hb;
      2'd2:    c = fwd ? 4'h1 : 4'hd;
      default: c = fwd ? 4'h1 : 4'h9;
    endcase
    return c;
  endfunction

  // Shared multiply-accumulate. It is forced to zero outside CALC so the multiplier
  // does not toggle while the unit is idle.
  always_comb begin
    mix_byte = 8'h00;
    if (state_q == StCalc) begin
      for (int i = 0; i < 4; i++) begin
        mix_byte = mix_byte ^ gmul(col_q[{cnt_q + 2'(i), 3'b000} +: 8], coef(enc_q, 2'(i)));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    enc_d   = enc_q;
    res_d   = res_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          col_d   = {rs2[31:16], rs1[15:0]};
          enc_d   = enc;
          res_d   = 32'h0;
          cnt_d   = 2'd0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (!valid) begin
          // The core withdrew the request: abort without completing.
          cnt_d   = 2'd0;
          state_d = StIdle;
        end else begin
          res_d[{cnt_q, 3'b000} +: 8] = mix_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        ready   = 1'b1;
        cnt_d   = 2'd0;
        state_d = StIdle;
`ifdef XC_AESMIX_CLEAR_EN
        col_d   = 32'h0;
        enc_d   = 1'b0;
        res_d   = 32'h0;
`endif
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      col_q   <= 32'h0;
      enc_q   <= 1'b0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      enc_q   <= enc_d;
      res_q   <= res_d;
    end
  end

  assign result = res_q;

endmodule
